// File: rtl/p251_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : p251_pkg
//  Description : Shared definitions for the GF(251) vector datapath:
//                field modulus, element width, vector-sequencer state
//                encoding and a modular-add helper used by p251_add.
//  Revision    : 1.0  initial release
// ============================================================================
package p251_pkg;

    localparam int Q      = 251;
    localparam int ELEM_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Operands are assumed to be in 0..Q-1, so one conditional subtract
    // of Q brings the 9-bit sum back into range.
    function automatic logic [ELEM_W-1:0] mod_q_add(
        input logic [ELEM_W-1:0] a,
        input logic [ELEM_W-1:0] b
    );
        logic [ELEM_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (ELEM_W+1)'(Q)) begin
            s = s - (ELEM_W+1)'(Q);
        end
        return s[ELEM_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/p251_add.sv
`default_nettype none
// ============================================================================
//  Module      : p251_add
//  Description : Single-cycle registered adder mod 251.
//                out = (in_1 + in_2) mod 251, o_done one cycle after i_start.
//  Ports       : i_clk, i_rst_n (sync, active-low), i_start,
//                in_1/in_2 (operands 0..250), out (result), o_done (pulse)
//  Revision    : 1.0  initial release
// ============================================================================
module p251_add
    import p251_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ELEM_W-1:0] in_1,
    input  logic [ELEM_W-1:0] in_2,
    output logic [ELEM_W-1:0] out,
    output logic              o_done
);

    logic [ELEM_W-1:0] r_sum;
    logic              r_done;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sum  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= i_start;
            if (i_start) begin
                r_sum <= mod_q_add(in_1, in_2);
            end
        end
    end

    assign out    = r_sum;
    assign o_done = r_done;

endmodule
`default_nettype wire

// File: rtl/p251_vec_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : p251_vec_add_ctrl
//  Description : Vector front end for p251_add. Streams A[i], B[i] out of two
//                synchronous-read RAMs, one pair per cycle, through a single
//                p251_add and writes C[i] = (A[i] + B[i]) mod 251 to RAM C.
//  Ports       : i_clk, i_rst_n (sync, active-low), i_start
//                o_busy, o_done           run status / completion pulse
//                o_a_en/o_a_addr/i_a_data RAM A read port
//                o_b_en/o_b_addr/i_b_data RAM B read port
//                o_c_we/o_c_addr/o_c_data RAM C write port
//  Revision    : 1.0  initial release
// ============================================================================
module p251_vec_add_ctrl
    import p251_pkg::*;
#(
    parameter int LEN     = 16,
    parameter int ADDR_W  = 4,
    parameter int ADD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_a_en,
    output logic              o_b_en,
    output logic [ADDR_W-1:0] o_a_addr,
    output logic [ADDR_W-1:0] o_b_addr,
    input  logic [ELEM_W-1:0] i_a_data,
    input  logic [ELEM_W-1:0] i_b_data,
    output logic              o_c_we,
    output logic [ADDR_W-1:0] o_c_addr,
    output logic [ELEM_W-1:0] o_c_data
);

    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(LEN - 1);

    // ADD_LAT only documents the adder's latency; write-back is timed by the
    // adder's own o_done, so any latency >= 1 works without change here.
    generate
        if (LEN < 2 || ADD_LAT < 1 || ADDR_W != $clog2(LEN)) begin : g_bad_params
            $error("p251_vec_add_ctrl: inconsistent LEN/ADDR_W/ADD_LAT");
        end
    endgenerate

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_rd_cnt;
    logic [ADDR_W-1:0] r_wr_cnt;
    logic              r_rd_vld;
    logic [ELEM_W-1:0] w_add_out;
    logic              w_add_done;
    logic              w_issue;
    logic              w_busy;
    logic              w_wr;

    assign w_issue = (r_state == ISSUE);
    assign w_busy  = (r_state != IDLE);
    // Qualifying with busy stops a stale adder result from reaching RAM C
    // outside a run.
    assign w_wr    = w_add_done & w_busy;

    // ------------------------------------------------------------------
    // State register, counters and read-valid pipeline bit
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            // RAM data arrives one cycle after the enable.
            r_rd_vld <= w_issue;
            if (r_state == IDLE && i_start) begin
                r_rd_cnt <= '0;
                r_wr_cnt <= '0;
            end else begin
                if (w_issue && r_rd_cnt != c_LAST) begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                end
                if (w_wr && r_wr_cnt != c_LAST) begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start)              w_state_nxt = ISSUE;
            ISSUE:   if (r_rd_cnt == c_LAST)   w_state_nxt = DRAIN;
            DRAIN:   if (w_wr && r_wr_cnt == c_LAST) w_state_nxt = DONE;
            DONE:                              w_state_nxt = IDLE;
            default:                           w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Field adder
    // ------------------------------------------------------------------
    p251_add u_add (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (r_rd_vld),
        .in_1    (i_a_data),
        .in_2    (i_b_data),
        .out     (w_add_out),
        .o_done  (w_add_done)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_busy   = w_busy;
    assign o_done   = (r_state == DONE);
    assign o_a_en   = w_issue;
    assign o_b_en   = w_issue;
    assign o_a_addr = r_rd_cnt;
    assign o_b_addr = r_rd_cnt;
    assign o_c_we   = w_wr;
    assign o_c_addr = r_wr_cnt;
    assign o_c_data = w_add_out;

endmodule
`default_nettype wire

// File: tb/tb_p251_vec_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_p251_vec_add_ctrl
//  Description : Self-checking bench for p251_vec_add_ctrl. RAMs A/B/C are
//                modelled as arrays; expected C is (A+B) mod 251 computed
//                directly, and run timing is checked against the cycle
//                offsets relative to start acceptance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_p251_vec_add_ctrl;

    localparam int LEN      = 16;
    localparam int ADDR_W   = 4;
    localparam int ADD_LAT  = 1;
    localparam int DONE_REL = LEN + ADD_LAT + 2;   // o_done cycle after t0
    localparam int SENT     = 255;                 // marks unwritten C cells

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              busy, done, a_en, b_en, c_we;
    logic [ADDR_W-1:0] a_addr, b_addr, c_addr;
    logic [7:0]        a_data, b_data, c_data;

    always #5 clk = ~clk;

    p251_vec_add_ctrl #(.LEN(LEN), .ADDR_W(ADDR_W), .ADD_LAT(ADD_LAT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .o_busy  (busy),
        .o_done  (done),
        .o_a_en  (a_en),
        .o_b_en  (b_en),
        .o_a_addr(a_addr),
        .o_b_addr(b_addr),
        .i_a_data(a_data),
        .i_b_data(b_data),
        .o_c_we  (c_we),
        .o_c_addr(c_addr),
        .o_c_data(c_data)
    );

    int mem_a [LEN];
    int mem_b [LEN];
    int mem_c [LEN];
    int exp_c [LEN];
    bit alias_a;

    int n_chk, n_bad;
    int rel, cur_rst;
    int n_wr, wr_bad_order, wr_bad_time, late_wr, n_done, done_at, n_busy, pair_bad;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic clear_stats();
        rel = 0; n_wr = 0; wr_bad_order = 0; wr_bad_time = 0; late_wr = 0;
        n_done = 0; done_at = -1; n_busy = 0; pair_bad = 0;
    endtask

    // One clock cycle: observe outputs at the negedge, update the RAM
    // model just after the posedge, return at the next negedge.
    task automatic tick();
        logic cwe, aen, ben;
        int   caddr, cdata, aaddr, baddr;
        cwe = c_we; aen = a_en; ben = b_en;
        caddr = int'(c_addr); cdata = int'(c_data);
        aaddr = int'(a_addr); baddr = int'(b_addr);
        if (cwe) begin
            if (caddr != n_wr) wr_bad_order++;
            if (rel != 2 + ADD_LAT + n_wr) wr_bad_time++;
            if (cur_rst >= 0 && rel > cur_rst + 1) late_wr++;
            n_wr++;
        end
        if (done) begin
            n_done++;
            done_at = rel;
        end
        if (busy) n_busy++;
        if (a_en != b_en || a_addr != b_addr) pair_bad++;
        @(posedge clk);
        #1;
        if (cwe) begin
            if (alias_a) mem_a[caddr] = cdata;
            else         mem_c[caddr] = cdata;
        end
        if (aen) a_data = 8'(mem_a[aaddr]);
        if (ben) b_data = 8'(mem_b[baddr]);
        @(negedge clk);
        rel++;
    endtask

    // Runs cycles t0..t0+DONE_REL; returns at the negedge of t0+DONE_REL+1.
    task automatic do_run(input bit hold, input int pulse_at, input int rst_at);
        clear_stats();
        cur_rst = rst_at;
        for (int i = 0; i < LEN; i++) exp_c[i] = (mem_a[i] + mem_b[i]) % 251;
        while (rel <= DONE_REL) begin
            start = (rel == 0) || hold || (rel == pulse_at);
            if (rst_at >= 0) rst_n = !(rel >= rst_at && rel < rst_at + 3);
            tick();
        end
        if (!hold) start = 1'b0;
    endtask

    function automatic int c_errs();
        int e;
        e = 0;
        for (int i = 0; i < LEN; i++) if (mem_c[i] != exp_c[i]) e++;
        return e;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < LEN; i++) begin
            mem_a[i] = int'($urandom_range(250));
            mem_b[i] = int'($urandom_range(250));
            mem_c[i] = SENT;
        end
    endtask

    task automatic check_normal(input string tag);
        chk({tag, "_c"},        c_errs(), 0);
        chk({tag, "_nwr"},      n_wr, LEN);
        chk({tag, "_done_at"},  done_at, DONE_REL);
        chk({tag, "_busy"},     n_busy, DONE_REL);
    endtask

    initial begin
        int wa [5] = '{1, 234, 240, 245, 250};
        int wb [5] = '{20, 31, 85, 165, 250};
        int wc [5] = '{21, 14, 74, 159, 249};
        int unchanged, e;

        n_chk = 0; n_bad = 0; cur_rst = -1; alias_a = 1'b0;
        rst_n = 1'b0; start = 1'b1; a_data = '0; b_data = '0;
        for (int i = 0; i < LEN; i++) begin
            mem_a[i] = 0; mem_b[i] = 0; mem_c[i] = SENT;
        end
        clear_stats();
        @(negedge clk);

        // Reset held with start high: all outputs zero, no reads.
        repeat (3) begin
            tick();
            chk("rst_outs", int'({busy, done, a_en, b_en, c_we,
                                  a_addr, b_addr, c_addr, c_data}), 0);
        end
        rst_n = 1'b1; start = 1'b0;
        repeat (2) tick();
        chk("idle_busy", int'(busy), 0);
        chk("idle_en",   int'(a_en | b_en), 0);

        // Modular wrap vectors.
        for (int i = 0; i < LEN; i++) begin
            mem_a[i] = (i < 5) ? wa[i] : 0;
            mem_b[i] = (i < 5) ? wb[i] : 0;
            mem_c[i] = SENT;
        end
        do_run(1'b0, -1, -1);
        for (int i = 0; i < 5; i++) chk($sformatf("wrap_c%0d", i), mem_c[i], wc[i]);
        check_normal("wrap");
        chk("wrap_order", wr_bad_order, 0);
        chk("wrap_wtime", wr_bad_time, 0);
        chk("wrap_ndone", n_done, 1);
        chk("wrap_pair",  pair_bad, 0);

        // Start held high for the whole run: one run, restart after DONE.
        fill_random();
        do_run(1'b1, -1, -1);
        chk("hold_ndone", n_done, 1);
        chk("hold_done_at", done_at, DONE_REL);
        chk("hold_idle", int'(busy), 0);
        tick();
        chk("hold_restart", int'(busy), 1);
        start = 1'b0;
        n_done = 0;
        repeat (DONE_REL) tick();
        chk("hold_run2_done", n_done, 1);
        chk("hold_run2_c", c_errs(), 0);

        // Extra start pulse mid-run is ignored.
        fill_random();
        do_run(1'b0, 5, -1);
        check_normal("pulse");
        chk("pulse_ndone", n_done, 1);
        repeat (3) tick();
        chk("pulse_after", int'(busy), 0);

        // Reset mid-run.
        fill_random();
        do_run(1'b0, -1, 8);
        chk("mrst_ndone", n_done, 0);
        chk("mrst_late", late_wr, 0);
        unchanged = 0;
        for (int i = 7; i < LEN; i++) if (mem_c[i] == SENT) unchanged++;
        chk("mrst_unchanged", unchanged, LEN - 7);
        e = 0;
        for (int i = 0; i < 5; i++) if (mem_c[i] != exp_c[i]) e++;
        chk("mrst_early_c", e, 0);
        cur_rst = -1;
        rst_n = 1'b1;
        fill_random();
        do_run(1'b0, -1, -1);
        check_normal("post_rst");

        // In place: C aliased to A.
        alias_a = 1'b1;
        for (int i = 0; i < LEN; i++) begin
            mem_a[i] = i; mem_b[i] = 250;
        end
        do_run(1'b0, -1, -1);
        e = 0;
        for (int i = 0; i < LEN; i++) if (mem_a[i] != (i + 250) % 251) e++;
        chk("inplace_errs", e, 0);
        chk("inplace_a0",  mem_a[0], 250);
        chk("inplace_a1",  mem_a[1], 0);
        chk("inplace_a15", mem_a[LEN-1], 14);
        alias_a = 1'b0;

        // Randomised runs.
        for (int r = 0; r < 200; r++) begin
            fill_random();
            do_run(1'b0, -1, -1);
            check_normal("rand");
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/p251_vec_add_ctrl.md
# p251_vec_add_ctrl

Sequencer that performs element-wise addition mod 251 of two length-LEN vectors, C[i] = (A[i] + B[i]) mod 251, using one p251_add instance. Reads A and B from two synchronous-read RAM ports, streams one element pair per cycle into the adder, and writes results to a third RAM port. Sits between the SDitH share/polynomial buffers and the field arithmetic as the vector-level front end of p251_add.

## Interface
Parameters:
- LEN, 16: vector length in elements (≥2)
- ADDR_W, 4: RAM address width, equal to $clog2(LEN)
- ADD_LAT, 1: p251_add cycles from i_start to o_done; only informs the timing budget, since writes are driven by the adder's o_done

Ports:
- i_clk  in  1  clock; all logic is rising-edge
- i_rst_n  in  1  reset; synchronous and active-low
- i_start  in  1  start request, sampled only in IDLE
- o_busy  out  1  high from the cycle after start acceptance through the o_done cycle
- o_done  out  1  one-cycle completion pulse
- o_a_en, o_b_en  out  1  read enables for RAM A and RAM B
- o_a_addr, o_b_addr  out  ADDR_W  read addresses; always equal
- i_a_data, i_b_data  in  8  read data, valid one cycle after the enable
- o_c_we  out  1  write enable for RAM C
- o_c_addr  out  ADDR_W  write address
- o_c_data  out  8  write data in 0..250

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: when i_start=1, clear rd_cnt and wr_cnt, then go to ISSUE. No other state samples i_start, so a start while busy is ignored.
- ISSUE: assert o_a_en=o_b_en=1 with address rd_cnt, then increment rd_cnt. After issuing address LEN-1, go to DRAIN. rd_cnt never wraps past LEN-1.
- Adder feed: a 1-bit read-valid register delays the enables by one cycle. While it is high, drive p251_add i_start=1 with in_1=i_a_data and in_2=i_b_data.
- Write-back: o_c_we is the adder's o_done, qualified by o_busy. o_c_data is the adder's out, o_c_addr is wr_cnt, and wr_cnt increments on each write.
- DRAIN: after the write at wr_cnt=LEN-1, go to DONE.
- DONE: assert o_done=1 for one cycle, then go to IDLE. If i_start is high in the following IDLE cycle, a new run starts.
- Arithmetic: 9-bit sum, with 251 subtracted when sum ≥ 251 (inside p251_add). Inputs are restricted to 0..250; out-of-range inputs are outside the contract.
- In-place (RAM C aliased to A or B) is legal: index i is read at least 2 cycles before it is written.
- Reset: when i_rst_n=0, the FSM goes to IDLE, counters and the read-valid register clear, and p251_add is reset. A write in flight is dropped and no further writes occur.
- Reset values: all outputs are 0.

## Timing
- Start is accepted at cycle t0 (IDLE, i_start=1).
- Read of element i: cycle t0+1+i.
- Adder start for element i: cycle t0+2+i.
- Write of element i: cycle t0+2+ADD_LAT+i.
- o_done: cycle t0+LEN+ADD_LAT+2. With the defaults this is t0+19.
- o_busy: high from t0+1 through the o_done cycle.
- Throughput: one element per cycle, with no bubbles inside a run.

## Structure
- Shared package p251_pkg:
  - Q=251 and ELEM_W=8
  - the FSM state enum (IDLE/ISSUE/DRAIN/DONE)
- Sub-module: exactly one p251_add, instantiated unchanged. Its i_start is driven by read-valid, in_1/in_2 by the RAM data, and out/o_done feed the write port.
- Counters, FSM and read-valid register are local to p251_vec_add_ctrl.

## Test plan
- Reset: hold i_rst_n=0 for 3 cycles → every output is 0 and the FSM is in IDLE; i_start during reset produces no enables.
- Wrap values: A={1,234,240,245,250,0,...}, B={20,31,85,165,250,0,...} → C={21,14,74,159,249,0,...}; o_done at t0+19; exactly 16 writes to addresses 0..15 in order.
- Start while busy: i_start held high for the whole run → exactly one run; a second run begins in the IDLE cycle after o_done; a pulse at t0+5 alone has no effect.
- Reset mid-run: deassert i_rst_n at t0+8 → writes stop, addresses 7..15 of C are unchanged, o_done never pulses; a fresh start afterwards completes normally.
- In-place: C aliased to A, A[i]=i, B[i]=250 → final A[i]=(i+250) mod 251, i.e. 250,0,1,...,14.
- Random: 200 runs with uniform values in 0..250 → C matches the (A+B) mod 251 reference model and o_busy duty is exactly LEN+ADD_LAT+2 cycles per run.
